// File: rtl/udp_tx_arbiter_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM state encoding,
// default timeout values, word and grant-index widths.
package udp_tx_arbiter_pkg;

  localparam int UDP_W           = 32;
  localparam int GRANT_W         = 2;
  localparam int DEF_ACK_TIMEOUT = 1024;
  localparam int DEF_EN_TIMEOUT  = 16;

  // 2-bit state encoding shared by RTL and bench.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_START = 2'd2,
    S_XFER  = 2'd3
  } state_e;

  // One counter serves both timeouts, so it is sized for the larger one.
  function automatic int cnt_width(input int ack_to, input int en_to);
    int max_to;
    max_to = (ack_to > en_to) ? ack_to : en_to;
    return (max_to <= 2) ? 1 : $clog2(max_to);
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Bundle of the per-source request/data signals and the UDP port handshake.
// master: the arbiter. slave: the sources and the UDP transmit port.
interface udp_tx_arbiter_if #(
  parameter int N_SRC = 2
);
  import udp_tx_arbiter_pkg::*;

  logic [N_SRC-1:0]       src_req;
  logic [N_SRC-1:0]       src_ack;
  logic [N_SRC-1:0]       src_enable;
  logic [UDP_W*N_SRC-1:0] src_data;
  logic                   m_req;
  logic                   m_ack;
  logic                   m_enable;
  logic [UDP_W-1:0]       m_data;
  logic [GRANT_W-1:0]     grant_id;
  logic                   timeout_err;

  modport master (
    input  src_req, src_enable, src_data, m_ack,
    output src_ack, m_req, m_enable, m_data, grant_id, timeout_err
  );

  modport slave (
    output src_req, src_enable, src_data, m_ack,
    input  src_ack, m_req, m_enable, m_data, grant_id, timeout_err
  );

endinterface

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the search starts one past the last
// grant and wraps modulo N_SRC; the first requesting source wins.
module rr_pick
  import udp_tx_arbiter_pkg::*;
#(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0]   req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] winner,
  output logic               valid
);

  localparam int IW = GRANT_W + 1;

  logic [IW-1:0] idx;

  // Walk candidates last+1, last+2, ... and keep the first one requesting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = {1'b0, last} + IW'(k);
      if (idx >= IW'(N_SRC)) idx = idx - IW'(N_SRC);
      for (int i = 0; i < N_SRC; i++) begin
        if (!valid && req[i] && (idx == IW'(i))) begin
          valid  = 1'b1;
          winner = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter granting one of N_SRC packet sources access to a single
// UDP transmit port. A grant runs request -> ack -> start -> transfer; both
// waiting phases are bounded by timeouts that abort back to idle.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int EN_TIMEOUT  = DEF_EN_TIMEOUT
) (
  input logic             clk,
  input logic             rst_n,
  udp_tx_arbiter_if.master bus
);

  localparam int            CNT_W    = cnt_width(ACK_TIMEOUT, EN_TIMEOUT);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_req_q, m_req_d;
  logic               m_enable_q, m_enable_d;
  logic [UDP_W-1:0]   m_data_q, m_data_d;
  logic               timeout_err_q, timeout_err_d;

  logic [GRANT_W-1:0] pick_winner;
  logic               pick_valid;
  logic               sel_enable;
  logic [UDP_W-1:0]   sel_data;
  logic [N_SRC-1:0]   src_ack;
  logic               in_data_phase;

  rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
    .req    (bus.src_req),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Route only the granted source's enable/data; all others are invisible.
  always_comb begin
    sel_enable = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_id_q == GRANT_W'(i)) begin
        sel_enable = bus.src_enable[i];
        sel_data   = bus.src_data[UDP_W*i +: UDP_W];
      end
    end
  end

  // Ack is passed straight through to the granted source in the same cycle.
  always_comb begin
    src_ack = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ack[i] = (state_q == S_REQ) && bus.m_ack && (grant_id_q == GRANT_W'(i));
    end
  end

  assign in_data_phase = (state_q == S_START) || (state_q == S_XFER);

  // Next-state, grant, timeout and registered-output computation.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    timeout_err_d = 1'b0;
    cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d    = S_REQ;
          grant_id_d = pick_winner;
          last_d     = pick_winner;
        end
      end
      S_REQ: begin
        // Ack is tested first so it beats a timeout expiring in the same cycle.
        if (bus.m_ack) begin
          state_d = S_START;
        end else if (cnt_q == ACK_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      S_START: begin
        if (sel_enable) begin
          state_d = S_XFER;
        end else if (cnt_q == EN_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      S_XFER: begin
        if (!sel_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Each state starts its own wait from zero.
    if (state_d != state_q) cnt_d = '0;

    m_req_d    = (state_d == S_REQ);
    m_enable_d = in_data_phase && sel_enable;
    m_data_d   = in_data_phase ? sel_data : '0;
  end

  // All state and outputs registered; reset aborts any packet immediately.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_id_q    <= '0;
      last_q        <= GRANT_W'(N_SRC - 1);
      cnt_q         <= '0;
      m_req_q       <= 1'b0;
      m_enable_q    <= 1'b0;
      m_data_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      m_req_q       <= m_req_d;
      m_enable_q    <= m_enable_d;
      m_data_q      <= m_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.src_ack     = src_ack;
  assign bus.m_req       = m_req_q;
  assign bus.m_enable    = m_enable_q;
  assign bus.m_data      = m_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: directed packets from a driver thread push the
// expected acks, words and timeout events into queues; a negedge monitor pops
// and compares whenever the DUT presents one.
module tb_udp_tx_arbiter;
  import udp_tx_arbiter_pkg::*;

  localparam int          N_SRC  = 2;
  localparam int          ACK_TO = 8;
  localparam int          EN_TO  = 4;
  localparam logic [31:0] NOISE  = 32'hDEAD_BEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  udp_tx_arbiter_if #(.N_SRC(N_SRC)) bus ();

  udp_tx_arbiter #(
    .N_SRC       (N_SRC),
    .ACK_TIMEOUT (ACK_TO),
    .EN_TIMEOUT  (EN_TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ack   = 0;
  int          cyc     = 0;
  bit          mon_on  = 1'b0;
  bit          bad_seen = 1'b0;
  bit          prev_en = 1'b0;
  logic [1:0]  prev_grant = '0;
  int          ack_q[$];
  logic [31:0] data_q[$];
  int          err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, required no event (t=%0t)", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The non-granted source toggles enable and drives junk data.
  task automatic noise_step(input int src, input bit noise);
    int o;
    if (noise) begin
      o = 1 - src;
      bus.src_enable[o] = ~bus.src_enable[o];
      bus.src_data[32*o +: 32] = NOISE;
    end
  endtask

  task automatic wait_mreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("m_req_seen", 32'(ok), 32'd1);
  endtask

  // One full packet: wait for m_req, ack after ack_delay cycles, raise enable
  // after en_delay START cycles, send nwords words base, base+1, ...
  task automatic do_packet(input int src, input int ack_delay, input int en_delay,
                           input int nwords, input logic [31:0] base,
                           input bit drop_req, input bit noise);
    bit ok;
    wait_mreq(ok);
    if (!ok) return;
    check("grant_id", 32'(bus.grant_id), 32'(src));
    repeat (ack_delay) begin tick(); noise_step(src, noise); end
    bus.m_ack = 1'b1;
    ack_q.push_back(src);
    tick();
    bus.m_ack = 1'b0;
    if (drop_req) bus.src_req[src] = 1'b0;
    noise_step(src, noise);
    repeat (en_delay) begin tick(); noise_step(src, noise); end
    for (int w = 0; w < nwords; w++) begin
      bus.src_enable[src] = 1'b1;
      bus.src_data[32*src +: 32] = base + 32'(w);
      data_q.push_back(base + 32'(w));
      tick();
      noise_step(src, noise);
    end
    bus.src_enable[src] = 1'b0;
    bus.src_data[32*src +: 32] = '0;
    tick();
    if (noise) begin
      bus.src_enable[1-src] = 1'b0;
      bus.src_data[32*(1-src) +: 32] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Cycle counter for latency measurements.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every ack pulse, data word and timeout pulse.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (bus.src_ack != '0) begin
          n_ack++;
          if (ack_q.size() == 0) unexpected("src_ack_unexpected", 32'(bus.src_ack));
          else begin
            e = ack_q.pop_front();
            check("src_ack_onehot", 32'(bus.src_ack), 32'(1) << e);
          end
        end
        if (bus.m_enable) begin
          if (prev_en) check("burst_same_src", 32'(bus.grant_id), 32'(prev_grant));
          if (data_q.size() == 0) unexpected("m_data_unexpected", bus.m_data);
          else check("m_data", bus.m_data, data_q.pop_front());
        end
        if (bus.timeout_err) begin
          if (err_q.size() == 0) unexpected("timeout_err_unexpected", 32'(bus.grant_id));
          else check("timeout_grant", 32'(bus.grant_id), 32'(err_q.pop_front()));
        end
        if (bus.m_data == NOISE) bad_seen = 1'b1;
        prev_en    = bus.m_enable;
        prev_grant = bus.grant_id;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int entry;
    bit saw_en;

    bus.src_req    = '0;
    bus.src_enable = '0;
    bus.src_data   = '0;
    bus.m_ack      = 1'b0;

    // Reset state, sampled while reset is still held.
    repeat (3) tick();
    @(negedge clk);
    check("rst_m_req",       32'(bus.m_req),       32'd0);
    check("rst_m_enable",    32'(bus.m_enable),    32'd0);
    check("rst_m_data",      bus.m_data,           32'd0);
    check("rst_src_ack",     32'(bus.src_ack),     32'd0);
    check("rst_grant_id",    32'(bus.grant_id),    32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    tick();
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Single source, ack 3 cycles after REQ entry, words 0x11..0x15.
    bus.src_req[0] = 1'b1;
    do_packet(0, 3, 0, 5, 32'h11, 1'b1, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    check("single_ack_count", 32'(n_ack),        32'd1);
    check("single_idle_mreq", 32'(bus.m_req),    32'd0);
    check("single_idle_men",  32'(bus.m_enable), 32'd0);
    tick();

    // Contention from reset: grant order 0,1,0,1.
    do_reset();
    bus.src_req = 2'b11;
    do_packet(0, 1, 0, 4, 32'h0100_0000, 1'b0, 1'b0);
    do_packet(1, 1, 0, 4, 32'h0200_0000, 1'b0, 1'b0);
    do_packet(0, 1, 0, 4, 32'h0300_0000, 1'b0, 1'b0);
    do_packet(1, 1, 0, 4, 32'h0400_0000, 1'b0, 1'b0);
    bus.src_req = 2'b00;
    repeat (2) tick();

    // Ack timeout: last grant was 1, so source 0 wins and times out after 8.
    bus.src_req = 2'b11;
    err_q.push_back(0);
    wait_mreq(ok);
    check("acktmo_grant", 32'(bus.grant_id), 32'd0);
    entry = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.timeout_err) break;
    end
    check("acktmo_cycles", 32'(cyc - entry), 32'(ACK_TO));
    check("acktmo_mreq_low", 32'(bus.m_req), 32'd0);
    // The pointer has moved past source 0; source 1 must be granted next.
    do_packet(1, 1, 0, 2, 32'h0500_0000, 1'b1, 1'b0);
    bus.src_req = 2'b00;
    repeat (2) tick();

    // Enable timeout: ack given, enable withheld for EN_TO cycles.
    bus.src_req[0] = 1'b1;
    err_q.push_back(0);
    wait_mreq(ok);
    tick();
    bus.m_ack = 1'b1;
    ack_q.push_back(0);
    tick();
    bus.m_ack = 1'b0;
    bus.src_req[0] = 1'b0;
    entry  = cyc;
    saw_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_enable) saw_en = 1'b1;
      if (bus.timeout_err) break;
    end
    check("entmo_cycles", 32'(cyc - entry), 32'(EN_TO));
    check("entmo_no_enable", 32'(saw_en), 32'd0);
    @(negedge clk);
    check("entmo_idle_mreq", 32'(bus.m_req), 32'd0);
    tick();

    // Isolation: source 1 toggles enable with 0xDEADBEEF during the packet.
    bus.src_req[0] = 1'b1;
    do_packet(0, 2, 0, 4, 32'hA000_0000, 1'b1, 1'b1);
    repeat (2) tick();

    // Boundary: ack on the last allowed REQ cycle wins over the timeout.
    bus.src_req[0] = 1'b1;
    do_packet(0, ACK_TO - 1, 0, 2, 32'hB000_0000, 1'b1, 1'b0);
    repeat (2) tick();

    // Boundary: enable on the last allowed START cycle still transfers.
    bus.src_req[0] = 1'b1;
    do_packet(0, 1, EN_TO - 1, 2, 32'hB100_0000, 1'b1, 1'b0);
    repeat (2) tick();

    // Reset mid-packet at word 3 of source 1; restart must go to source 0.
    bus.src_req[1] = 1'b1;
    wait_mreq(ok);
    check("rstpkt_grant", 32'(bus.grant_id), 32'd1);
    tick();
    bus.m_ack = 1'b1;
    ack_q.push_back(1);
    tick();
    bus.m_ack = 1'b0;
    bus.src_req[1] = 1'b0;
    bus.src_enable[1] = 1'b1;
    bus.src_data[63:32] = 32'hC000_0001;
    data_q.push_back(32'hC000_0001);
    tick();
    bus.src_data[63:32] = 32'hC000_0002;
    data_q.push_back(32'hC000_0002);
    tick();
    bus.src_data[63:32] = 32'hC000_0003;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.src_enable[1] = 1'b0;
    bus.src_data[63:32] = '0;
    bus.src_req = 2'b11;
    @(negedge clk);
    check("rstpkt_m_enable", 32'(bus.m_enable), 32'd0);
    check("rstpkt_grant_id", 32'(bus.grant_id), 32'd0);
    check("rstpkt_m_req",    32'(bus.m_req),    32'd0);
    do_packet(0, 2, 0, 3, 32'hC0DE_0000, 1'b1, 1'b0);
    bus.src_req = 2'b00;

    repeat (4) tick();
    check("ack_q_drained",  32'(ack_q.size()),  32'd0);
    check("data_q_drained", 32'(data_q.size()), 32'd0);
    check("err_q_drained",  32'(err_q.size()),  32'd0);
    check("noise_never_out", 32'(bad_seen),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter N_SRC, default 2, number of requesting packet sources (2..4).
REQ-002 Parameter ACK_TIMEOUT, default 1024, max cycles in S_REQ waiting for m_ack.
REQ-003 Parameter EN_TIMEOUT, default 16, max cycles in S_START waiting for the granted source's enable.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 src_req  in  N_SRC  per-source packet request, level.
REQ-007 src_ack  out  N_SRC  per-source grant acknowledge, one-cycle pulse.
REQ-008 src_enable  in  N_SRC  per-source word-valid; packet ends when it falls.
REQ-009 src_data  in  32*N_SRC  per-source word; source i at bits [32*i+31:32*i].
REQ-010 m_req  out  1  request to the UDP transmit port.
REQ-011 m_ack  in  1  UDP transmit port acknowledge.
REQ-012 m_enable  out  1  registered word-valid to the UDP port.
REQ-013 m_data  out  32  registered word to the UDP port.
REQ-014 grant_id  out  2  index of the currently or last granted source.
REQ-015 timeout_err  out  1  one-cycle pulse on any timeout abort.

Function
REQ-016 States: S_IDLE, S_REQ, S_START, S_XFER.
REQ-017 S_IDLE: when any src_req is high, latch the winner into grant_id by round-robin and go to S_REQ. Search starts at (last grant + 1) mod N_SRC. After reset the search starts at source 0.
REQ-018 S_REQ: m_req is 1. The winner's src_req is not re-sampled. On m_ack=1, pulse src_ack[grant_id] in the same cycle (combinational from m_ack) and go to S_START.
REQ-019 S_REQ timeout: after ACK_TIMEOUT cycles without m_ack, pulse timeout_err and go to S_IDLE. The round-robin pointer advances past the timed-out source.
REQ-020 S_START: m_req is 0. When src_enable[grant_id]=1, go to S_XFER. After EN_TIMEOUT cycles without enable, pulse timeout_err and go to S_IDLE.
REQ-021 S_XFER: when src_enable[grant_id]=0, go to S_IDLE. The packet is complete.
REQ-022 m_enable and m_data are registered once from source grant_id while in S_START or S_XFER, giving one cycle of latency. Outside those states, m_enable is 0 and m_data is 0.
REQ-023 Enables and data from non-granted sources are ignored at all times. src_ack of a non-granted source is always 0.
REQ-024 At most one src_ack bit is high in any cycle.
REQ-025 Earliest re-arbitration is the cycle after the S_XFER-to-S_IDLE transition. Back-to-back packets from different sources are therefore separated by at least one idle cycle on m_enable.
REQ-026 Timeout counters are clog2-wide, saturate, and clear on every state entry.
REQ-027 If m_ack and the timeout expiry occur in the same cycle, the ack wins: no timeout_err, and the next state is S_START.
REQ-028 If src_enable is already high on entry to S_START, transition to S_XFER on that first S_START cycle.

Reset
REQ-029 While rst_n=0 at a clk edge: state goes to S_IDLE, m_req=0, m_enable=0, m_data=0, src_ack=0, grant_id=0, timeout_err=0, counters=0, and the round-robin pointer is set so that source 0 wins next.
REQ-030 Reset asserted mid-packet aborts immediately. There is no flush, and m_enable is 0 in the cycle after the reset edge.

Structure
REQ-031 A shared package holds the state encoding (2-bit localparams), the default ACK_TIMEOUT and EN_TIMEOUT values, and the UDP word width (32).
REQ-032 One sub-module, rr_pick: a combinational round-robin priority selector with inputs req vector and last grant, and outputs winner index and valid.
REQ-033 The datapath mux and the FSM stay in udp_tx_arbiter.

Verification
REQ-034 Single source: src_req[0]=1, m_ack after 3 cycles, then enable high for 5 words 0x11..0x15 -> src_ack[0] pulses once; m_data shows 0x11..0x15 one cycle delayed; returns to S_IDLE.
REQ-035 Contention: src_req=2'b11 held, each packet 4 words -> grant order 0,1,0,1; every src_ack is single-bit; at least 1 idle cycle between packets.
REQ-036 Ack timeout with ACK_TIMEOUT=8: m_ack never asserted -> timeout_err pulses 8 cycles after S_REQ entry; the next grant goes to the other requesting source.
REQ-037 Enable timeout with EN_TIMEOUT=4: ack given, enable withheld -> timeout_err after 4 cycles, m_enable stays 0, state returns to S_IDLE.
REQ-038 Isolation: the non-granted source toggles enable with data 0xDEADBEEF during source 0's packet -> 0xDEADBEEF never appears on m_data.
REQ-039 Reset mid-packet: rst_n=0 for 1 cycle at word 3 -> m_enable=0 next cycle, grant_id=0; a new request restarts cleanly at source 0.
